// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift 8 data + odd parity + stop, then ack check.
// Optional watchdog compiled in with `define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1800000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_in,
    input  logic       cmd_latch,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    state_t      r_state, w_state_nx;
    logic [IW-1:0] r_inh_cnt, w_inh_nx;
    logic [3:0]  r_bit_cnt, w_bit_nx;
    logic [9:0]  r_frame, w_frame_nx;
    logic        r_data_low, w_low_nx;
    logic        r_done, w_done_nx;
    logic        r_ack_err, w_ack_err_nx;

    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_dat_meta, r_dat_sync;
    logic w_fall;

    assign w_fall = r_clk_prev & ~r_clk_sync;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int            WW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] r_wd, w_wd_nx;
    logic          r_to, w_to_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_frame    <= '0;
            r_data_low <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_inh_cnt  <= w_inh_nx;
            r_bit_cnt  <= w_bit_nx;
            r_frame    <= w_frame_nx;
            r_data_low <= w_low_nx;
            r_done     <= w_done_nx;
            r_ack_err  <= w_ack_err_nx;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
            r_to <= 1'b0;
        end else begin
            r_wd <= w_wd_nx;
            r_to <= w_to_nx;
        end
    end
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_inh_nx     = r_inh_cnt;
        w_bit_nx     = r_bit_cnt;
        w_frame_nx   = r_frame;
        w_low_nx     = r_data_low;
        w_done_nx    = 1'b0;
        w_ack_err_nx = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        w_wd_nx      = r_wd;
        w_to_nx      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_latch) begin
                    w_frame_nx = {1'b1, ~^cmd_in, cmd_in};
                    w_inh_nx   = '0;
                    w_state_nx = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) w_state_nx = S_RTS;
                else                       w_inh_nx   = r_inh_cnt + 1'b1;
            end
            S_RTS: begin
                // Start bit stays on the line until the device's first falling edge.
                w_low_nx   = 1'b1;
                w_bit_nx   = '0;
                w_state_nx = S_SHIFT;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                w_wd_nx    = WW'(1);
`endif
            end
            S_SHIFT: begin
                if (w_fall) begin
                    w_low_nx = ~r_frame[r_bit_cnt];
                    if (r_bit_cnt == 4'd9) w_state_nx = S_ACK;
                    else                   w_bit_nx   = r_bit_cnt + 4'd1;
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    if (!r_dat_sync) begin
                        w_state_nx = S_WAIT_IDLE;
                    end else begin
                        w_ack_err_nx = 1'b1;
                        w_state_nx   = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync && r_dat_sync) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog overrides any same-cycle completion so the pulses stay exclusive.
        if (r_state == S_SHIFT || r_state == S_ACK || r_state == S_WAIT_IDLE) begin
            if (r_wd == WD_LAST) begin
                w_state_nx   = S_IDLE;
                w_to_nx      = 1'b1;
                w_done_nx    = 1'b0;
                w_ack_err_nx = 1'b0;
            end else begin
                w_wd_nx = r_wd + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_RTS);
        ps2_data_oe = (r_state == S_RTS) ||
                      (((r_state == S_SHIFT) || (r_state == S_ACK)) && r_data_low);
        busy        = (r_state != S_IDLE);
    end

    assign done    = r_done;
    assign ack_err = r_ack_err;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    assign timeout_err = r_to;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
